// File: rtl/i2s_rx.sv
// I2S receiver: oversampled capture of bclk/lrck/data into parallel PCM samples.
// Optional slot-length checking is enabled by defining I2S_RX_FRAME_CHECK_EN.
module i2s_rx #(
    parameter int SAMPLE_WIDTH = 16,
    parameter int SLOT_WIDTH   = 32,
    parameter int DELAY_BITS   = 1
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    i2s_bclk,
    input  logic                    i2s_lrck,
    input  logic                    i2s_data,
    output logic [SAMPLE_WIDTH-1:0] sample_data,
    output logic                    sample_right,
    output logic                    sample_valid,
    output logic [SAMPLE_WIDTH-1:0] left_sample,
    output logic [SAMPLE_WIDTH-1:0] right_sample,
    output logic                    frame_error
);

    localparam int CW = $clog2(SLOT_WIDTH) + 1;
    localparam logic [CW-1:0] CNT_MAX  = {CW{1'b1}};
    localparam logic [CW-1:0] LAST_IDX = CW'(DELAY_BITS + SAMPLE_WIDTH - 1);
    localparam logic [CW-1:0] SKIP_END = CW'((DELAY_BITS > 1) ? DELAY_BITS - 1 : 0);

    typedef enum logic [2:0] {
        ST_ARM   = 3'd0,
        ST_WAIT  = 3'd1,
        ST_SKIP  = 3'd2,
        ST_SHIFT = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

    logic bclk_meta, bclk_sync, bclk_last;
    logic lrck_meta, lrck_sync, lrck_q;
    logic data_meta, data_sync, data_q;
    logic rise;

    state_t                  state, state_nxt;
    logic [SAMPLE_WIDTH-1:0] shreg, shreg_nxt, shifted;
    logic [CW-1:0]           bit_cnt, bit_cnt_nxt, bit_inc;
    logic                    channel, channel_nxt;
    logic                    prev_lrck, prev_lrck_nxt;
    logic                    complete, complete_nxt;
    logic                    slot_edge;

    // Pin synchronizers and registered bclk rising-edge strobe with aligned lrck/data
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bclk_meta <= 1'b0;
            bclk_sync <= 1'b0;
            bclk_last <= 1'b0;
            lrck_meta <= 1'b0;
            lrck_sync <= 1'b0;
            data_meta <= 1'b0;
            data_sync <= 1'b0;
            rise      <= 1'b0;
            lrck_q    <= 1'b0;
            data_q    <= 1'b0;
        end else begin
            bclk_meta <= i2s_bclk;
            bclk_sync <= bclk_meta;
            bclk_last <= bclk_sync;
            lrck_meta <= i2s_lrck;
            lrck_sync <= lrck_meta;
            data_meta <= i2s_data;
            data_sync <= data_meta;
            rise      <= bclk_sync & ~bclk_last;
            lrck_q    <= lrck_sync;
            data_q    <= data_sync;
        end
    end

    // FSM and capture state registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= ST_ARM;
            shreg     <= {SAMPLE_WIDTH{1'b0}};
            bit_cnt   <= {CW{1'b0}};
            channel   <= 1'b0;
            prev_lrck <= 1'b0;
            complete  <= 1'b0;
        end else begin
            state     <= state_nxt;
            shreg     <= shreg_nxt;
            bit_cnt   <= bit_cnt_nxt;
            channel   <= channel_nxt;
            prev_lrck <= prev_lrck_nxt;
            complete  <= complete_nxt;
        end
    end

    // Next-state logic; bit_cnt holds the index of the current bit within the slot
    always_comb begin
        state_nxt     = state;
        shreg_nxt     = shreg;
        bit_cnt_nxt   = bit_cnt;
        channel_nxt   = channel;
        prev_lrck_nxt = prev_lrck;
        complete_nxt  = 1'b0;
        shifted       = {shreg[SAMPLE_WIDTH-2:0], data_q};
        bit_inc       = (bit_cnt == CNT_MAX) ? bit_cnt : bit_cnt + CW'(1);
        slot_edge     = (lrck_q != prev_lrck);
        if (rise) begin
            prev_lrck_nxt = lrck_q;
            bit_cnt_nxt   = bit_inc;
            if (state == ST_ARM) begin
                state_nxt = ST_WAIT;
            end else if (slot_edge) begin
                // Any edge restarts capture; a partial sample in SKIP/SHIFT is dropped
                channel_nxt = lrck_q;
                bit_cnt_nxt = {CW{1'b0}};
                if (DELAY_BITS == 0) begin
                    shreg_nxt = shifted;
                    state_nxt = ST_SHIFT;
                end else if (DELAY_BITS == 1) begin
                    state_nxt = ST_SHIFT;
                end else begin
                    state_nxt = ST_SKIP;
                end
            end else begin
                case (state)
                    ST_SKIP: begin
                        state_nxt = (bit_inc == SKIP_END) ? ST_SHIFT : ST_SKIP;
                    end
                    ST_SHIFT: begin
                        shreg_nxt = shifted;
                        if (bit_inc == LAST_IDX) begin
                            state_nxt    = ST_DONE;
                            complete_nxt = 1'b1;
                        end else begin
                            state_nxt = ST_SHIFT;
                        end
                    end
                    default: begin
                        state_nxt = state;
                    end
                endcase
            end
        end else begin
            state_nxt = state;
        end
    end

    // Output registers load one cycle after the final sample bit is shifted
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sample_valid <= 1'b0;
            sample_data  <= {SAMPLE_WIDTH{1'b0}};
            sample_right <= 1'b0;
            left_sample  <= {SAMPLE_WIDTH{1'b0}};
            right_sample <= {SAMPLE_WIDTH{1'b0}};
        end else begin
            sample_valid <= complete;
            if (complete) begin
                sample_data  <= shreg;
                sample_right <= channel;
                if (channel) begin
                    right_sample <= shreg;
                end else begin
                    left_sample <= shreg;
                end
            end
        end
    end

`ifdef I2S_RX_FRAME_CHECK_EN
    localparam logic [CW-1:0] SLOT_END = CW'(SLOT_WIDTH - 1);

    // Slot-length check at every edge that closes a slot (the first slot after ARM opens in WAIT)
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            frame_error <= 1'b0;
        end else begin
            frame_error <= rise && slot_edge && (state != ST_ARM) && (state != ST_WAIT)
                           && (bit_cnt != SLOT_END);
        end
    end
`else
    assign frame_error = 1'b0;
`endif

endmodule

// File: tb/tb_i2s_rx.sv
// Scoreboard bench for i2s_rx: one standard I2S instance and one left-justified instance
// share bclk/lrck; each has its own data line and expected-sample queue.
`timescale 1ns/1ps
module tb_i2s_rx;

    logic clk = 1'b0;
    logic reset;
    logic bclk, lrck, data0, data1;

    logic [15:0] sd0, ls0, rs0, sd1, ls1, rs1;
    logic        sr0, sv0, fe0, sr1, sv1, fe1;

    int vectors     = 0;
    int miscompares = 0;
    int fe_cnt0     = 0;
    int fe_cnt1     = 0;

    logic [16:0] q0[$];
    logic [16:0] q1[$];
    logic [16:0] e0, e1;
    time         lsb_t0, lsb_t1;

`ifdef I2S_RX_FRAME_CHECK_EN
    localparam int FE_EXP = 2;
`else
    localparam int FE_EXP = 0;
`endif

    always #5 clk = ~clk;

    i2s_rx dut0 (
        .clk(clk), .reset(reset), .i2s_bclk(bclk), .i2s_lrck(lrck), .i2s_data(data0),
        .sample_data(sd0), .sample_right(sr0), .sample_valid(sv0),
        .left_sample(ls0), .right_sample(rs0), .frame_error(fe0)
    );

    i2s_rx #(.DELAY_BITS(0)) dut1 (
        .clk(clk), .reset(reset), .i2s_bclk(bclk), .i2s_lrck(lrck), .i2s_data(data1),
        .sample_data(sd1), .sample_right(sr1), .sample_valid(sv1),
        .left_sample(ls1), .right_sample(rs1), .frame_error(fe1)
    );

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // One slot of nbits bclk periods (8 clk each); sample bits placed per instance delay
    task automatic send_slot(input logic ch, input logic [15:0] val, input int nbits, input bit push);
        if (push && nbits >= 17) q0.push_back({ch, val});
        if (push && nbits >= 16) q1.push_back({ch, val});
        for (int i = 0; i < nbits; i++) begin
            bclk = 1'b0;
            lrck = ch;
            if (i >= 1 && i <= 16) data0 = val[16-i];
            else                   data0 = 1'($urandom_range(1, 0));
            if (i <= 15) data1 = val[15-i];
            else         data1 = 1'($urandom_range(1, 0));
            repeat (4) @(negedge clk);
            bclk = 1'b1;
            if (i == 16) lsb_t0 = $time;
            if (i == 15) lsb_t1 = $time;
            repeat (4) @(negedge clk);
        end
    endtask

    // Scoreboard for the standard I2S instance
    always @(negedge clk) begin
        if (!reset) begin
            if (sv0) begin
                if (q0.size() == 0) begin
                    check_eq("unexpected_valid0", 64'(sv0), 64'd0);
                end else begin
                    e0 = q0.pop_front();
                    check_eq("data0", 64'(sd0), 64'(e0[15:0]));
                    check_eq("chan0", 64'(sr0), 64'(e0[16]));
                    check_eq("held0", 64'(e0[16] ? rs0 : ls0), 64'(e0[15:0]));
                    check_eq("latency0", 64'($time - lsb_t0), 64'd50);
                end
            end
            if (fe0) fe_cnt0++;
        end
    end

    // Scoreboard for the left-justified instance
    always @(negedge clk) begin
        if (!reset) begin
            if (sv1) begin
                if (q1.size() == 0) begin
                    check_eq("unexpected_valid1", 64'(sv1), 64'd0);
                end else begin
                    e1 = q1.pop_front();
                    check_eq("data1", 64'(sd1), 64'(e1[15:0]));
                    check_eq("chan1", 64'(sr1), 64'(e1[16]));
                    check_eq("held1", 64'(e1[16] ? rs1 : ls1), 64'(e1[15:0]));
                    check_eq("latency1", 64'($time - lsb_t1), 64'd50);
                end
            end
            if (fe1) fe_cnt1++;
        end
    end

    initial begin
        reset = 1'b1;
        bclk  = 1'b0;
        lrck  = 1'b1;
        data0 = 1'b0;
        data1 = 1'b0;
        repeat (3) @(negedge clk);
        check_eq("reset_state0", 64'({sd0, sr0, sv0, ls0, rs0, fe0}), 64'd0);
        check_eq("reset_state1", 64'({sd1, sr1, sv1, ls1, rs1, fe1}), 64'd0);
        reset = 1'b0;
        repeat (2) @(negedge clk);

        send_slot(1'b1, 16'h0000, 4, 1'b0);
        send_slot(1'b0, 16'h8001, 32, 1'b1);
        send_slot(1'b1, 16'h7FFE, 32, 1'b1);
        check_eq("nominal_left0",  64'(ls0), 64'h8001);
        check_eq("nominal_right0", 64'(rs0), 64'h7FFE);
        check_eq("nominal_left1",  64'(ls1), 64'h8001);
        check_eq("nominal_right1", 64'(rs1), 64'h7FFE);

        send_slot(1'b0, 16'hDEAD, 10, 1'b1);
        send_slot(1'b1, 16'h00FF, 32, 1'b1);
        check_eq("short_left_held0", 64'(ls0), 64'h8001);
        check_eq("short_right0",     64'(rs0), 64'h00FF);

        send_slot(1'b0, 16'hA5A5, 40, 1'b1);
        send_slot(1'b1, 16'h1111, 32, 1'b1);

        send_slot(1'b0, 16'h0F0F, 32, 1'b1);
        send_slot(1'b1, 16'hBEEF, 8, 1'b0);
        check_eq("pre_reset_q0", 64'(q0.size()), 64'd0);
        check_eq("pre_reset_q1", 64'(q1.size()), 64'd0);
        reset = 1'b1;
        #1;
        check_eq("mid_reset0", 64'({sd0, sr0, sv0, ls0, rs0, fe0}), 64'd0);
        check_eq("mid_reset1", 64'({sd1, sr1, sv1, ls1, rs1, fe1}), 64'd0);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        send_slot(1'b1, 16'hBEEF, 24, 1'b0);
        send_slot(1'b0, 16'h1357, 32, 1'b1);
        send_slot(1'b1, 16'h2468, 32, 1'b1);
        check_eq("post_reset_left0",  64'(ls0), 64'h1357);
        check_eq("post_reset_right0", 64'(rs0), 64'h2468);

        for (int f = 0; f < 100; f++) begin
            send_slot(1'b0, 16'(2 * f), 32, 1'b1);
            send_slot(1'b1, 16'(2 * f + 1), 32, 1'b1);
        end
        send_slot(1'b0, 16'h0000, 4, 1'b0);
        repeat (20) @(negedge clk);

        check_eq("drops0", 64'(q0.size()), 64'd0);
        check_eq("drops1", 64'(q1.size()), 64'd0);
        check_eq("frame_errors0", 64'(fe_cnt0), 64'(FE_EXP));
        check_eq("frame_errors1", 64'(fe_cnt1), 64'(FE_EXP));
        check_eq("final_left0",  64'(ls0), 64'd198);
        check_eq("final_right0", 64'(rs0), 64'd199);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
